// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
// Takes FFT bins in bit-reversed order from the last SDF butterfly stage and
// replays each N-point frame in natural bin order (0..N-1) on a valid/ready stream.
// A two-bank ping-pong buffer lets one frame fill while the previous one drains,
// so back-to-back frames stream at one sample per clock.
// Optional feature macro: FFT_REORDER_INDEX_EN adds the out_idx port (natural bin index).
module fft_bitrev_reorder #(
   parameter int DATA_WIDTH = 16,
   parameter int N_POINTS   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_val,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_re,
   input  logic [DATA_WIDTH-1:0] in_im,
   output logic                  out_val,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_re,
   output logic [DATA_WIDTH-1:0] out_im,
   output logic                  out_last
`ifdef FFT_REORDER_INDEX_EN
   ,
   output logic [$clog2(N_POINTS)-1:0] out_idx
`endif
);

   localparam int LOG2N = $clog2(N_POINTS);
   localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_POINTS - 1);

   // Both banks live in one array; the top address bit selects the bank.
   logic [2*DATA_WIDTH-1:0] mem [0:2*N_POINTS-1];

   logic [1:0]            bank_full_reg;
   logic [1:0]            bank_full_next;
   logic                  wr_sel_reg;
   logic [LOG2N-1:0]      wr_cnt_reg;
   logic                  rd_sel_reg;
   logic [LOG2N-1:0]      rd_cnt_reg;
   logic [LOG2N-1:0]      rd_rev;

   logic                  out_val_reg;
   logic                  out_last_reg;
   logic [DATA_WIDTH-1:0] out_re_reg;
   logic [DATA_WIDTH-1:0] out_im_reg;

   logic                  wr_accept;
   logic                  wr_wrap;
   logic                  rd_advance;
   logic                  rd_wrap;

   // Handshake decisions come from registered state only, so in_ready has no
   // combinational path from out_ready.
   assign in_ready   = ~bank_full_reg[wr_sel_reg];
   assign wr_accept  = in_val & in_ready;
   assign wr_wrap    = wr_accept & (wr_cnt_reg == CNT_LAST);
   assign rd_advance = bank_full_reg[rd_sel_reg] & (~out_val_reg | out_ready);
   assign rd_wrap    = rd_advance & (rd_cnt_reg == CNT_LAST);

   // Read address: natural bin index rd_cnt lives at slot bitrev(rd_cnt).
   generate
      for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
         assign rd_rev[gi] = rd_cnt_reg[LOG2N-1-gi];
      end
   endgenerate

   // Full flags: writer marks its bank full on the last sample, reader frees its
   // bank on the last bin. The two never address the same bank in one cycle.
   always_comb begin
      bank_full_next = bank_full_reg;
      if (wr_wrap) begin
         bank_full_next[wr_sel_reg] = 1'b1;
      end
      if (rd_wrap) begin
         bank_full_next[rd_sel_reg] = 1'b0;
      end
   end

   // Control state: bank pointers, counters and full flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bank_full_reg <= 2'b00;
         wr_sel_reg    <= 1'b0;
         wr_cnt_reg    <= '0;
         rd_sel_reg    <= 1'b0;
         rd_cnt_reg    <= '0;
      end else begin
         bank_full_reg <= bank_full_next;
         if (wr_accept) begin
            wr_cnt_reg <= wr_cnt_reg + CNT_ONE;
            if (wr_wrap) begin
               wr_sel_reg <= ~wr_sel_reg;
            end
         end
         if (rd_advance) begin
            rd_cnt_reg <= rd_cnt_reg + CNT_ONE;
            if (rd_wrap) begin
               rd_sel_reg <= ~rd_sel_reg;
            end
         end
      end
   end

   // Sample storage: contents need no reset, the full flags gate every read.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[{wr_sel_reg, wr_cnt_reg}] <= {in_re, in_im};
      end
   end

   // Output register: registered read from the buffer, held while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_val_reg  <= 1'b0;
         out_last_reg <= 1'b0;
         out_re_reg   <= '0;
         out_im_reg   <= '0;
      end else if (rd_advance) begin
         out_val_reg  <= 1'b1;
         out_last_reg <= (rd_cnt_reg == CNT_LAST);
         {out_re_reg, out_im_reg} <= mem[{rd_sel_reg, rd_rev}];
      end else if (out_val_reg && out_ready) begin
         out_val_reg  <= 1'b0;
      end
   end

`ifdef FFT_REORDER_INDEX_EN
   logic [LOG2N-1:0] out_idx_reg;

   // Natural bin index travels with the data and holds during stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_idx_reg <= '0;
      end else if (rd_advance) begin
         out_idx_reg <= rd_cnt_reg;
      end
   end

   assign out_idx = out_idx_reg;
`endif

   assign out_val  = out_val_reg;
   assign out_last = out_last_reg;
   assign out_re   = out_re_reg;
   assign out_im   = out_im_reg;

endmodule
